// File: rtl/brick_field_if.sv
// brick_field_if: groups the frame/ball/pixel inputs and the collision,
// score and colour outputs of the brick row into one bundle.
// master = the driving environment, slave = the brick_field block.
interface brick_field_if #(
    parameter int NUM_BRICKS = 10
);
    logic                  tick_move;
    logic                  respawn;
    logic [9:0]            x;
    logic [9:0]            y;
    logic                  active_pixels;
    logic [9:0]            ball_x;
    logic [9:0]            ball_y;
    logic [9:0]            ball_width;
    logic [9:0]            ball_height;
    logic [NUM_BRICKS-1:0] collide_block;
    logic [9:0]            block_x;
    logic [9:0]            block_y;
    logic [9:0]            block_width;
    logic [9:0]            block_height;
    logic [15:0]           score;
    logic                  field_clear;
    logic [23:0]           vga_color;

    modport master (
        output tick_move, respawn, x, y, active_pixels,
               ball_x, ball_y, ball_width, ball_height,
        input  collide_block, block_x, block_y, block_width, block_height,
               score, field_clear, vga_color
    );

    modport slave (
        input  tick_move, respawn, x, y, active_pixels,
               ball_x, ball_y, ball_width, ball_height,
        output collide_block, block_x, block_y, block_width, block_height,
               score, field_clear, vga_color
    );
endinterface

// File: rtl/brick_field.sv
// brick_field: a row of breakable bricks. Each frame tick snapshots the ball
// rectangle and scans one brick per clock; the lowest-index live brick that
// overlaps is hit (one per tick). Also renders brick pixels and flags a
// cleared field.
// Optional build macro BRICK_FIELD_TWO_HIT_EN: every brick takes two hits,
// a wounded brick renders at half brightness, score counts kills only.
module brick_field #(
    parameter int          NUM_BRICKS  = 10,
    parameter int          BRICK_W     = 60,
    parameter int          BRICK_H     = 20,
    parameter int          GAP         = 2,
    parameter int          X0          = 6,
    parameter int          ROW_Y       = 40,
    parameter logic [23:0] BRICK_COLOR = 24'hff4000
) (
    input  logic         clk,
    input  logic         rst,
    brick_field_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, HIT, CLEARED} state_e;

    localparam logic [9:0]  ROW_Y_L   = 10'(ROW_Y);
    localparam logic [10:0] ROW_TOP   = 11'(ROW_Y);
    localparam logic [10:0] ROW_BOT   = 11'(ROW_Y + BRICK_H);
    localparam logic [10:0] BRICK_W_L = 11'(BRICK_W);

    // Left edge of brick i.
    function automatic logic [9:0] brick_left(input logic [3:0] i);
        return 10'(X0 + int'(i) * (BRICK_W + GAP));
    endfunction

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [9:0]            snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [9:0]            snap_w_q, snap_w_d, snap_h_q, snap_h_d;
    logic [NUM_BRICKS-1:0] collide_q, collide_d;
    logic [9:0]            block_x_q, block_x_d, block_y_q, block_y_d;
    logic [15:0]           score_q, score_d;
    logic                  field_clear_q, field_clear_d;
    logic [NUM_BRICKS-1:0] alive;
    logic                  cur_alive, overlap, score_inc;
    logic [9:0]            cur_bx;
    logic [23:0]           color_c;

`ifdef BRICK_FIELD_TWO_HIT_EN
    localparam logic [23:0] HALF_COLOR = {1'b0, BRICK_COLOR[23:17],
                                          1'b0, BRICK_COLOR[15:9],
                                          1'b0, BRICK_COLOR[7:1]};
    logic [1:0] hits_q [NUM_BRICKS];
    logic [1:0] hits_d [NUM_BRICKS];

    // A brick is alive while it still has hits left.
    always_comb begin
        for (int i = 0; i < NUM_BRICKS; i++) alive[i] = (hits_q[i] != 2'd0);
    end
`else
    logic [NUM_BRICKS-1:0] alive_q, alive_d;

    // Alive bits are the brick state directly.
    always_comb alive = alive_q;
`endif

    // Geometry and liveness of the brick under test this scan cycle.
    always_comb begin
        cur_alive = 1'b0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            if (idx_q == 4'(i)) cur_alive = alive[i];
        end
        cur_bx  = brick_left(idx_q);
        overlap = ({1'b0, snap_x_q} < {1'b0, cur_bx} + BRICK_W_L) &&
                  ({1'b0, snap_x_q} + {1'b0, snap_w_q} > {1'b0, cur_bx}) &&
                  ({1'b0, snap_y_q} < ROW_BOT) &&
                  ({1'b0, snap_y_q} + {1'b0, snap_h_q} > ROW_TOP);
    end

    // Next-state logic for the scan FSM and all registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        snap_w_d      = snap_w_q;
        snap_h_d      = snap_h_q;
        collide_d     = '0;
        block_x_d     = block_x_q;
        block_y_d     = block_y_q;
        score_d       = score_q;
        field_clear_d = field_clear_q;
        score_inc     = 1'b0;
`ifdef BRICK_FIELD_TWO_HIT_EN
        hits_d = hits_q;
`else
        alive_d = alive_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tick_move) begin
                    snap_x_d = bus.ball_x;
                    snap_y_d = bus.ball_y;
                    snap_w_d = bus.ball_width;
                    snap_h_d = bus.ball_height;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (overlap && cur_alive) begin
                    block_x_d = cur_bx;
                    block_y_d = ROW_Y_L;
                    state_d   = HIT;
                    for (int i = 0; i < NUM_BRICKS; i++) begin
                        if (idx_q == 4'(i)) begin
                            collide_d[i] = 1'b1;
`ifdef BRICK_FIELD_TWO_HIT_EN
                            hits_d[i] = hits_q[i] - 2'd1;
                            score_inc = (hits_q[i] == 2'd1);
`else
                            alive_d[i] = 1'b0;
                            score_inc  = 1'b1;
`endif
                        end
                    end
                    if (score_inc && score_q != 16'hffff) score_d = score_q + 16'd1;
                end else if (idx_q == 4'(NUM_BRICKS - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            HIT: begin
                if (|alive) begin
                    state_d = IDLE;
                end else begin
                    state_d       = CLEARED;
                    field_clear_d = 1'b1;
                end
            end
            CLEARED: ;
            default: state_d = IDLE;
        endcase
        // Respawn overrides the FSM but leaves the score alone.
        if (bus.respawn) begin
            state_d       = IDLE;
            field_clear_d = 1'b0;
            collide_d     = '0;
            score_d       = score_q;
`ifdef BRICK_FIELD_TWO_HIT_EN
            for (int i = 0; i < NUM_BRICKS; i++) hits_d[i] = 2'd2;
`else
            alive_d = '1;
`endif
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_w_q      <= '0;
            snap_h_q      <= '0;
            collide_q     <= '0;
            block_x_q     <= 10'(X0);
            block_y_q     <= ROW_Y_L;
            score_q       <= '0;
            field_clear_q <= 1'b0;
            // NOTE: the per-brick store is reset because reset must restore a full row.
`ifdef BRICK_FIELD_TWO_HIT_EN
            for (int i = 0; i < NUM_BRICKS; i++) hits_q[i] <= 2'd2;
`else
            alive_q <= '1;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
            snap_w_q      <= snap_w_d;
            snap_h_q      <= snap_h_d;
            collide_q     <= collide_d;
            block_x_q     <= block_x_d;
            block_y_q     <= block_y_d;
            score_q       <= score_d;
            field_clear_q <= field_clear_d;
`ifdef BRICK_FIELD_TWO_HIT_EN
            for (int i = 0; i < NUM_BRICKS; i++) hits_q[i] <= hits_d[i];
`else
            alive_q <= alive_d;
`endif
        end
    end

    // Pixel renderer: colour of the live brick under (x,y), black elsewhere.
    always_comb begin
        color_c = '0;
        if (bus.active_pixels &&
            {1'b0, bus.y} >= ROW_TOP && {1'b0, bus.y} < ROW_BOT) begin
            for (int i = 0; i < NUM_BRICKS; i++) begin
                if (alive[i] &&
                    {1'b0, bus.x} >= {1'b0, brick_left(4'(i))} &&
                    {1'b0, bus.x} <  {1'b0, brick_left(4'(i))} + BRICK_W_L) begin
`ifdef BRICK_FIELD_TWO_HIT_EN
                    color_c = (hits_q[i] == 2'd1) ? HALF_COLOR : BRICK_COLOR;
`else
                    color_c = BRICK_COLOR;
`endif
                end
            end
        end
    end

    assign bus.collide_block = collide_q;
    assign bus.block_x       = block_x_q;
    assign bus.block_y       = block_y_q;
    assign bus.block_width   = 10'(BRICK_W);
    assign bus.block_height  = 10'(BRICK_H);
    assign bus.score         = score_q;
    assign bus.field_clear   = field_clear_q;
    assign bus.vga_color     = color_c;
endmodule

// File: tb/tb_brick_field.sv
// tb_brick_field: directed self-checking bench for brick_field with
// default geometry (10 bricks, 60x20, gap 2, x0 6, row y 40).
module tb_brick_field;
    localparam int NB = 10;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [23:0] exp;
    } pix_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    brick_field_if #(.NUM_BRICKS(NB)) bus ();
    brick_field dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse tick_move, then watch 14 cycles for collide pulses.
    // lat counts cycles from the tick cycle (0) to the first pulse.
    task automatic do_tick(output logic [NB-1:0] pv, output int lat, output int np);
        pv = '0; lat = -1; np = 0;
        bus.tick_move = 1'b1;
        step();
        bus.tick_move = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.collide_block != '0) begin
                np++;
                if (lat < 0) begin
                    lat = c;
                    pv  = bus.collide_block;
                end
            end
            step();
        end
    endtask

    task automatic set_ball(input int bx, input int by, input int bw, input int bh);
        bus.ball_x      = 10'(bx);
        bus.ball_y      = 10'(by);
        bus.ball_width  = 10'(bw);
        bus.ball_height = 10'(bh);
    endtask

    task automatic check_pix(input string name, input int px, input int py,
                             input logic act, input logic [23:0] exp);
        bus.x = 10'(px);
        bus.y = 10'(py);
        bus.active_pixels = act;
        #1;
        check(name, 32'(bus.vga_color), 32'(exp));
    endtask

    pix_vec_t   vt [13];
    logic [NB-1:0] pv;
    int         lat, np;
    int         order [5];

    initial begin
        vt[0]  = '{10'd66,  10'd45, 1'b1, 24'h000000}; // gap between 0 and 1
        vt[1]  = '{10'd70,  10'd45, 1'b1, 24'hff4000}; // inside brick 1
        vt[2]  = '{10'd70,  10'd45, 1'b0, 24'h000000}; // blanked
        vt[3]  = '{10'd6,   10'd40, 1'b1, 24'hff4000}; // brick 0 top-left
        vt[4]  = '{10'd65,  10'd40, 1'b1, 24'hff4000}; // brick 0 last column
        vt[5]  = '{10'd67,  10'd40, 1'b1, 24'h000000}; // gap last column
        vt[6]  = '{10'd68,  10'd40, 1'b1, 24'hff4000}; // brick 1 first column
        vt[7]  = '{10'd6,   10'd39, 1'b1, 24'h000000}; // above the row
        vt[8]  = '{10'd6,   10'd59, 1'b1, 24'hff4000}; // last row line
        vt[9]  = '{10'd6,   10'd60, 1'b1, 24'h000000}; // below the row
        vt[10] = '{10'd5,   10'd50, 1'b1, 24'h000000}; // left of brick 0
        vt[11] = '{10'd623, 10'd50, 1'b1, 24'hff4000}; // brick 9 last column
        vt[12] = '{10'd624, 10'd50, 1'b1, 24'h000000}; // right of brick 9
        order  = '{1, 4, 6, 7, 8};

        bus.tick_move = 1'b0; bus.respawn = 1'b0;
        bus.x = '0; bus.y = '0; bus.active_pixels = 1'b0;
        set_ball(0, 0, 0, 0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_collide", 32'(bus.collide_block), 32'd0);
        check("rst_score",   32'(bus.score), 32'd0);
        check("rst_clear",   32'(bus.field_clear), 32'd0);
        check("rst_block_x", 32'(bus.block_x), 32'd6);
        check("rst_block_y", 32'(bus.block_y), 32'd40);
        check("rst_block_w", 32'(bus.block_width), 32'd60);
        check("rst_block_h", 32'(bus.block_height), 32'd20);

        // Pixel table on the full row
        for (int i = 0; i < 13; i++) begin
            bus.x = vt[i].x; bus.y = vt[i].y; bus.active_pixels = vt[i].act;
            #1;
            check($sformatf("pix%0d", i), 32'(bus.vga_color), 32'(vt[i].exp));
        end

`ifdef BRICK_FIELD_TWO_HIT_EN
        // Two hits on brick 0: two pulses, one score increment
        set_ball(6, 40, 20, 20);
        do_tick(pv, lat, np);
        check("th1_pulse", 32'(pv), 32'd1);
        check("th1_lat",   32'(lat), 32'd2);
        check("th1_score", 32'(bus.score), 32'd0);
        check_pix("th1_half", 10, 45, 1'b1, 24'h7f2000);
        do_tick(pv, lat, np);
        check("th2_pulse", 32'(pv), 32'd1);
        check("th2_np",    32'(np), 32'd1);
        check("th2_score", 32'(bus.score), 32'd1);
        check_pix("th2_dead", 10, 45, 1'b1, 24'h000000);
        do_tick(pv, lat, np);
        check("th3_np", 32'(np), 32'd0);
`else
        // First hit on brick 0
        set_ball(6, 40, 20, 20);
        do_tick(pv, lat, np);
        check("hit0_pulse", 32'(pv), 32'd1);
        check("hit0_lat",   32'(lat), 32'd2);
        check("hit0_np",    32'(np), 32'd1);
        check("hit0_bx",    32'(bus.block_x), 32'd6);
        check("hit0_by",    32'(bus.block_y), 32'd40);
        check("hit0_score", 32'(bus.score), 32'd1);

        // Same tick again (brick 0 dead), ball moved mid-scan to brick 5,
        // tick in last scan cycle ignored, tick right after accepted.
        bus.tick_move = 1'b1;
        step();
        bus.tick_move = 1'b0;
        set_ball(316, 40, 20, 20);
        pv = '0; lat = -1; np = 0;
        for (int c = 1; c <= 22; c++) begin
            bus.tick_move = (c == 10 || c == 11);
            if (bus.collide_block != '0) begin
                np++;
                if (lat < 0) begin lat = c; pv = bus.collide_block; end
            end
            if (c == 10) check("rescan_score", 32'(bus.score), 32'd1);
            step();
        end
        bus.tick_move = 1'b0;
        check("scan_len_lat",   32'(lat), 32'd18);
        check("scan_len_pulse", 32'(pv), 32'h20);
        check("scan_len_np",    32'(np), 32'd1);
        check("brick5_bx",      32'(bus.block_x), 32'd316);

        // Ball straddles bricks 2 and 3: lowest index first
        set_ball(184, 40, 20, 20);
        do_tick(pv, lat, np);
        check("b2_pulse", 32'(pv), 32'h4);
        check("b2_lat",   32'(lat), 32'd4);
        check("b2_np",    32'(np), 32'd1);
        check("b2_bx",    32'(bus.block_x), 32'd130);
        do_tick(pv, lat, np);
        check("b3_pulse", 32'(pv), 32'h8);
        check("b3_lat",   32'(lat), 32'd5);
        check("b3_score", 32'(bus.score), 32'd4);

        // Clear the rest with a ball spanning the whole row
        set_ball(0, 40, 1000, 20);
        for (int k = 0; k < 5; k++) begin
            do_tick(pv, lat, np);
            check($sformatf("kill%0d_pulse", order[k]), 32'(pv), 32'(1) << order[k]);
            check($sformatf("kill%0d_lat", order[k]), 32'(lat), 32'(order[k] + 2));
        end
        bus.tick_move = 1'b1;
        step();
        bus.tick_move = 1'b0;
        for (int c = 1; c < 11; c++) step();
        check("kill9_pulse", 32'(bus.collide_block), 32'h200);
        check("kill9_clear_lo", 32'(bus.field_clear), 32'd0);
        step();
        check("cleared_flag",    32'(bus.field_clear), 32'd1);
        check("cleared_collide", 32'(bus.collide_block), 32'd0);
        check("cleared_score",   32'(bus.score), 32'd10);
        do_tick(pv, lat, np);
        check("cleared_np",    32'(np), 32'd0);
        check("cleared_stays", 32'(bus.field_clear), 32'd1);
        check_pix("cleared_black", 70, 45, 1'b1, 24'h000000);

        // Respawn restores the row and keeps the score
        bus.respawn = 1'b1;
        step();
        bus.respawn = 1'b0;
        check("resp_clear", 32'(bus.field_clear), 32'd0);
        check("resp_score", 32'(bus.score), 32'd10);
        for (int i = 0; i < NB; i++)
            check_pix($sformatf("resp_pix%0d", i), 36 + i * 62, 50, 1'b1, 24'hff4000);
`endif

        // Reset during a scan aimed at brick 9
        set_ball(564, 40, 20, 20);
        bus.tick_move = 1'b1;
        step();
        bus.tick_move = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_collide", 32'(bus.collide_block), 32'd0);
        check("midrst_score",   32'(bus.score), 32'd0);
        check("midrst_clear",   32'(bus.field_clear), 32'd0);
        check("midrst_bx",      32'(bus.block_x), 32'd6);
        np = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.collide_block != '0) np++;
            step();
        end
        check("midrst_nopulse", 32'(np), 32'd0);
        set_ball(6, 40, 20, 20);
        do_tick(pv, lat, np);
        check("midrst_hit0_pulse", 32'(pv), 32'd1);
        check("midrst_hit0_lat",   32'(lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
